// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
package pc_seq_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PCSRC_PC4 = 2'd0,
    PCSRC_BR  = 2'd1,
    PCSRC_J   = 2'd2,
    PCSRC_JR  = 2'd3
  } pc_src_t;

endpackage

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - combinational next-PC resolution (jr > jump > taken branch > pc+4)
module next_pc_logic
  import pc_seq_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        branch_i,
  input  logic        branch_ne_i,
  input  logic        zero_i,
  input  logic        jump_i,
  input  logic        jr_i,
  input  logic [31:0] branch_off_i,
  input  logic [25:0] jump_idx_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_o,
  output pc_src_t     pc_src_o,
  output logic        misaligned_o
);

  logic [31:0] pc4;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic        taken;

  assign pc4   = pc_i + 32'(WORD_BYTES);
  // BNE inverts the sense of the Zero gate.
  assign taken = branch_i & (zero_i ^ branch_ne_i);
  assign btgt  = pc4 + (branch_off_i << 2);
  assign jtgt  = {pc4[31:28], jump_idx_i, 2'b00};

  assign misaligned_o = jr_i && (jr_target_i[1:0] != 2'b00);

  always_comb begin
    next_pc_o = pc4;
    pc_src_o  = PCSRC_PC4;
    if (jr_i) begin
      // A misaligned JR leaves the PC where it is; the sequencer halts.
      next_pc_o = misaligned_o ? pc_i : jr_target_i;
      pc_src_o  = PCSRC_JR;
    end else if (jump_i) begin
      next_pc_o = jtgt;
      pc_src_o  = PCSRC_J;
    end else if (taken) begin
      next_pc_o = btgt;
      pc_src_o  = PCSRC_BR;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/PC controller: owns the PC, fetches over req/ack, retires on ex_done
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              ex_done,
  input  logic              branch,
  input  logic              branch_ne,
  input  logic              zero,
  input  logic              jump,
  input  logic              jr,
  input  logic [31:0]       branch_off,
  input  logic [25:0]       jump_idx,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        pc_src,
  output logic [31:0]       instr_count,
  output logic              misaligned_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  pc_src_t           pc_src_q, pc_src_d;
  logic [31:0]       instr_count_q, instr_count_d;
  logic              misaligned_q, misaligned_d;

  logic [ADDR_W-1:0] next_pc;
  pc_src_t           next_src;
  logic              jr_misaligned;

  next_pc_logic u_next_pc (
    .pc_i         (pc_q),
    .branch_i     (branch),
    .branch_ne_i  (branch_ne),
    .zero_i       (zero),
    .jump_i       (jump),
    .jr_i         (jr),
    .branch_off_i (branch_off),
    .jump_idx_i   (jump_idx),
    .jr_target_i  (jr_target),
    .next_pc_o    (next_pc),
    .pc_src_o     (next_src),
    .misaligned_o (jr_misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_src_d      = pc_src_q;
    instr_count_d = instr_count_q;
    misaligned_d  = misaligned_q;
    imem_req      = 1'b0;
    instr_valid   = 1'b0;

    unique case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        imem_req = !stall;
        if (!stall) begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            state_d = EXEC;
          end else begin
            state_d = WAIT;
          end
        end
      end

      // Once issued, the request is held through stall until the ack arrives.
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end

      EXEC: begin
        instr_valid = 1'b1;
        if (ex_done) begin
          instr_count_d = instr_count_q + 32'd1;
          pc_d          = next_pc;
          pc_src_d      = next_src;
          if (jr_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = HALT;
          end else begin
            state_d = FETCH;
          end
        end
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      pc_src_q      <= PCSRC_PC4;
      instr_count_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_src_q      <= pc_src_d;
      instr_count_q <= instr_count_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign pc_src         = pc_src_q;
  assign instr_count    = instr_count_q;
  assign misaligned_err = misaligned_q;

endmodule
